// File: rtl/hyperload_pkg.sv
// Shared types and constants for the hyperload byte feeder: session states,
// status/control bit positions and default I/O port addresses.
package hyperload_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    localparam int unsigned STAT_AVAIL  = 0;
    localparam int unsigned STAT_EOF    = 1;
    localparam int unsigned STAT_ERR    = 2;
    localparam int unsigned STAT_OVR    = 3;
    localparam int unsigned STAT_SUM_OK = 4;

    localparam int unsigned CTRL_ABORT = 0;
    localparam int unsigned CTRL_CLEAR = 1;

    localparam logic [7:0] DEFAULT_PORT_DATA = 8'hE0;
    localparam logic [7:0] DEFAULT_PORT_STAT = 8'hE1;

endpackage

// File: rtl/hl_fifo.sv
// Synchronous DEPTH x 8 FIFO with head-of-queue output, occupancy count and flush.
// Push into a full FIFO or pop from an empty one is ignored.
module hl_fifo #(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = (AW)'(1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly log2(DEPTH) wide, so increment wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hyperload_feeder.sv
// Host-to-Z80 byte feeder for the patched fast-load routine; drives ROM patch override.
// Optional HYPERLOAD_CHECKSUM_EN adds a running sum of popped bytes at PORT_STAT+1.
module hyperload_feeder
    import hyperload_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter logic [7:0]  PORT_DATA = DEFAULT_PORT_DATA,
    parameter logic [7:0]  PORT_STAT = DEFAULT_PORT_STAT,
    parameter logic [23:0] TIMEOUT   = 24'd3_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arm,
    input  logic [7:0] host_data,
    input  logic       host_valid,
    input  logic       host_last,
    output logic       host_ready,
    input  logic [7:0] cpu_a,
    input  logic       cpu_iorq_n,
    input  logic       cpu_rd_n,
    input  logic       cpu_wr_n,
    input  logic [7:0] cpu_d_in,
    output logic [7:0] cpu_d_out,
    output logic       cpu_d_oe,
    output logic       override,
    output logic       done
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    state_t      state, state_nxt;
    logic [7:0]  fifo_head;
    logic        fifo_full, fifo_empty;
    logic [AW:0] fifo_count;

    logic        rd_strobe, wr_strobe;
    logic        rd_s1, rd_s2, wr_s1, wr_s2;
    logic        rd_rise, wr_rise;
    logic [7:0]  a_q;
    logic [1:0]  d_q;
    logic        accept, pop, abort, clear, timeout_hit, last_pop, set_err, arm_ok;
    logic        eof, err, sum_ok;
    logic [23:0] tmo_cnt;
    logic [7:0]  status;
    logic        unused_d_bits;

    assign unused_d_bits = ^cpu_d_in[7:2];

`ifdef HYPERLOAD_CHECKSUM_EN
    logic [7:0] sum;
    assign rd_strobe = !cpu_iorq_n && !cpu_rd_n &&
                       (cpu_a == PORT_DATA || cpu_a == PORT_STAT || cpu_a == PORT_STAT + 8'd1);
`else
    assign rd_strobe = !cpu_iorq_n && !cpu_rd_n && (cpu_a == PORT_DATA || cpu_a == PORT_STAT);
`endif
    assign wr_strobe = !cpu_iorq_n && !cpu_wr_n && (cpu_a == PORT_STAT);
    assign cpu_d_oe  = rd_strobe;

    assign rd_rise = rd_s1 && !rd_s2;
    assign wr_rise = wr_s1 && !wr_s2;

    assign host_ready  = (state == ARMED || state == STREAM) && !fifo_full;
    assign accept      = host_valid && host_ready;
    assign pop         = rd_rise && (a_q == PORT_DATA) && !fifo_empty;
    assign abort       = wr_rise && d_q[CTRL_ABORT] && (state == ARMED || state == STREAM);
    assign clear       = wr_rise && d_q[CTRL_CLEAR] && (state == IDLE);
    assign timeout_hit = (state == STREAM) && (tmo_cnt >= TIMEOUT) && !accept;
    assign last_pop    = (state == DRAIN) && pop && (fifo_count == CNT_ONE);
    assign arm_ok      = arm && (state == IDLE);

    assign override = (state == ARMED) || (state == STREAM) || (state == DRAIN);
    assign done     = (state == DONE);

    hl_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (set_err),
        .push  (accept),
        .din   (host_data),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        set_err   = 1'b0;
        case (state)
            IDLE:   if (arm_ok) state_nxt = ARMED;
            ARMED: begin
                if (abort) begin
                    state_nxt = DONE;
                    set_err   = 1'b1;
                end else if (accept) begin
                    state_nxt = host_last ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                if (abort || timeout_hit) begin
                    state_nxt = DONE;
                    set_err   = 1'b1;
                end else if (accept && host_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN:  if (last_pop) state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // CPU strobes are sampled then edge-detected so a long IORQ acts only once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_s1 <= 1'b0;
            rd_s2 <= 1'b0;
            wr_s1 <= 1'b0;
            wr_s2 <= 1'b0;
            a_q   <= '0;
            d_q   <= '0;
        end else begin
            rd_s1 <= rd_strobe;
            rd_s2 <= rd_s1;
            wr_s1 <= wr_strobe;
            wr_s2 <= wr_s1;
            a_q   <= cpu_a;
            d_q   <= cpu_d_in[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eof <= 1'b0;
            err <= 1'b0;
        end else if (clear) begin
            eof <= 1'b0;
            err <= 1'b0;
        end else begin
            if (last_pop) eof <= 1'b1;
            if (set_err)  err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state != STREAM || accept || pop) begin
            tmo_cnt <= '0;
        end else if (fifo_empty && tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 24'd1;
        end
    end

`ifdef HYPERLOAD_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (arm_ok) begin
            sum <= '0;
        end else if (pop) begin
            sum <= sum + fifo_head;
        end
    end
    assign sum_ok = eof && (sum == '0);
`else
    assign sum_ok = 1'b0;
`endif

    always_comb begin
        status              = '0;
        status[STAT_AVAIL]  = !fifo_empty;
        status[STAT_EOF]    = eof;
        status[STAT_ERR]    = err;
        status[STAT_OVR]    = override;
        status[STAT_SUM_OK] = sum_ok;
    end

    // Read data is captured once per access and held, so the popped byte stays on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_d_out <= 8'hFF;
        end else if (!rd_s1) begin
            cpu_d_out <= 8'hFF;
        end else if (rd_rise) begin
            if (a_q == PORT_DATA) begin
                cpu_d_out <= fifo_empty ? 8'hFF : fifo_head;
            end else if (a_q == PORT_STAT) begin
                cpu_d_out <= status;
`ifdef HYPERLOAD_CHECKSUM_EN
            end else if (a_q == PORT_STAT + 8'd1) begin
                cpu_d_out <= sum;
`endif
            end else begin
                cpu_d_out <= 8'hFF;
            end
        end
    end

endmodule
